// File: rtl/vend_change_dispenser.sv
// vend_change_dispenser: returns leftover credit as coins, largest denomination
// first, from four finite inventories. It pulses one solenoid per coin and flags
// Short when exact change cannot be made.
//
// Handshake: Start is a request that is accepted only in IDLE, and only when
// Refill is low in the same cycle. Requests at any other time are dropped, not
// queued. Done is a one-cycle completion strobe. Busy marks the interval between
// acceptance and Done. The caller has no way to apply backpressure.
module vend_change_dispenser #(
    parameter int PULSE_CYCLES = 3,   // solenoid high time, >= 1
    parameter int GAP_CYCLES   = 2,   // low time after each pulse, >= 1
    parameter int INIT_COUNT   = 8    // coins per denomination at reset/refill
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Start,
    input  logic [7:0] Credit,
    input  logic       Refill,
    output logic       DispDollar,
    output logic       DispFifty,
    output logic       DispTen,
    output logic       DispFive,
    output logic [7:0] Remaining,
    output logic [3:0] Empty,
    output logic       Busy,
    output logic       Done,
    output logic       Short,
    output logic [2:0] fsm_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_PULSE  = 3'd2,
        S_GAP    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [7:0] INIT       = 8'(INIT_COUNT);
    localparam logic [7:0] PULSE_LAST = 8'(PULSE_CYCLES - 1);
    localparam logic [7:0] GAP_LAST   = 8'(GAP_CYCLES - 1);

    // Coin index order matches Empty: 3=dollar, 2=fifty, 1=ten, 0=five.
    state_t     state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic [3:0] sel_q, sel_d;          // one-hot coin being pulsed
    logic [7:0] rem_q, rem_d;
    logic [7:0] count_q [4];
    logic [7:0] count_d [4];
    logic       short_q, short_d;

    logic [3:0] pick;                  // one-hot greedy choice, 0 if none fits
    logic [1:0] pick_idx;
    logic [7:0] pick_val;

    assign Remaining = rem_q;
    assign Short     = short_q;
    assign fsm_state = state_q;

    // Greedy selection: largest denomination that fits the remainder and is in stock.
    always_comb begin
        pick     = 4'b0000;
        pick_idx = 2'd0;
        pick_val = 8'd0;
        if (count_q[3] != 8'd0 && rem_q >= 8'd100) begin
            pick = 4'b1000; pick_idx = 2'd3; pick_val = 8'd100;
        end else if (count_q[2] != 8'd0 && rem_q >= 8'd50) begin
            pick = 4'b0100; pick_idx = 2'd2; pick_val = 8'd50;
        end else if (count_q[1] != 8'd0 && rem_q >= 8'd10) begin
            pick = 4'b0010; pick_idx = 2'd1; pick_val = 8'd10;
        end else if (count_q[0] != 8'd0 && rem_q >= 8'd5) begin
            pick = 4'b0001; pick_idx = 2'd0; pick_val = 8'd5;
        end
    end

    // Next-state logic, plus the next values of the remainder, inventory and Short.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        sel_d   = sel_q;
        rem_d   = rem_q;
        count_d = count_q;
        short_d = short_q;
        case (state_q)
            S_IDLE: begin
                if (Refill) begin
                    for (int i = 0; i < 4; i++) count_d[i] = INIT;
                end else if (Start) begin
                    rem_d   = Credit;
                    short_d = 1'b0;
                    state_d = S_SELECT;
                end
            end
            S_SELECT: begin
                if (rem_q == 8'd0) begin
                    state_d = S_DONE;
                end else if (pick == 4'b0000) begin
                    short_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    sel_d             = pick;
                    rem_d             = rem_q - pick_val;
                    count_d[pick_idx] = count_q[pick_idx] - 8'd1;
                    timer_d           = 8'd0;
                    state_d           = S_PULSE;
                end
            end
            S_PULSE: begin
                if (timer_q == PULSE_LAST) begin
                    timer_d = 8'd0;
                    state_d = S_GAP;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            S_GAP: begin
                if (timer_q == GAP_LAST) begin
                    timer_d = 8'd0;
                    state_d = S_SELECT;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers. Outputs are registered from the next state,
    // so they are aligned with the state they describe.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= S_IDLE;
            timer_q    <= 8'd0;
            sel_q      <= 4'b0000;
            rem_q      <= 8'd0;
            short_q    <= 1'b0;
            for (int i = 0; i < 4; i++) count_q[i] <= INIT;
            DispDollar <= 1'b0;
            DispFifty  <= 1'b0;
            DispTen    <= 1'b0;
            DispFive   <= 1'b0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            Empty      <= {4{INIT_COUNT == 0}};
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            sel_q   <= sel_d;
            rem_q   <= rem_d;
            short_q <= short_d;
            count_q <= count_d;
            {DispDollar, DispFifty, DispTen, DispFive} <=
                (state_d == S_PULSE) ? sel_d : 4'b0000;
            Busy <= (state_d == S_SELECT) || (state_d == S_PULSE) || (state_d == S_GAP);
            Done <= (state_d == S_DONE);
            for (int i = 0; i < 4; i++) Empty[i] <= (count_d[i] == 8'd0);
        end
    end

endmodule

// File: tb/tb_vend_change_dispenser.sv
// Directed bench for vend_change_dispenser. It checks the cycle-by-cycle solenoid,
// Busy, Done and Short trace of each request against hand-derived coin lists.
module tb_vend_change_dispenser;

    localparam logic [3:0] C_D = 4'b1000;   // dollar
    localparam logic [3:0] C_F = 4'b0100;   // fifty
    localparam logic [3:0] C_T = 4'b0010;   // ten
    localparam logic [3:0] C_V = 4'b0001;   // five

    // clock / reset
    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       RST, Start, Refill;
    logic [7:0] Credit;
    logic       DispDollar, DispFifty, DispTen, DispFive;
    logic [7:0] Remaining;
    logic [3:0] Empty;
    logic       Busy, Done, Short;
    logic [2:0] fsm_state;

    int tests = 0;
    int fails = 0;

    // Expected per-cycle {Disp[3:0], Busy, Done, Short}.
    logic [6:0] exp_q[$];

    vend_change_dispenser #(.PULSE_CYCLES(3), .GAP_CYCLES(2), .INIT_COUNT(8)) dut (
        .CLK(CLK), .RST(RST), .Start(Start), .Credit(Credit), .Refill(Refill),
        .DispDollar(DispDollar), .DispFifty(DispFifty), .DispTen(DispTen),
        .DispFive(DispFive), .Remaining(Remaining), .Empty(Empty), .Busy(Busy),
        .Done(Done), .Short(Short), .fsm_state(fsm_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] observed();
        return {DispDollar, DispFifty, DispTen, DispFive, Busy, Done, Short};
    endfunction

    // Build the expected trace for n coins. Coin i is coins[4i+3:4i]. Offset j is
    // the j-th cycle after the edge that takes Start.
    task automatic build_expected(input int n, input logic [15:0] coins, input logic exp_short);
        exp_q.delete();
        for (int j = 1; j <= 6 * n + 3; j++) begin
            logic [3:0] d;
            logic b, dn, s;
            int ph;
            d = 4'b0; b = 1'b0; dn = 1'b0; s = 1'b0;
            if (j <= 6 * n) begin
                ph = (j - 1) % 6;
                b  = 1'b1;
                if (ph >= 1 && ph <= 3) d = coins[4 * ((j - 1) / 6) +: 4];
            end else if (j == 6 * n + 1) begin
                b = 1'b1;
            end else if (j == 6 * n + 2) begin
                dn = 1'b1;
                s  = exp_short;
            end else begin
                s = exp_short;
            end
            exp_q.push_back({d, b, dn, s});
        end
    endtask

    // Driver and scoreboard for one request. poke != 0 raises Start and Refill
    // for one cycle at that offset; both must be ignored while the unit is busy.
    task automatic run_credit(input logic [7:0] credit, input int n, input logic [15:0] coins,
                              input logic exp_short, input logic [7:0] exp_rem, input int poke);
        int j;
        logic [6:0] e;
        build_expected(n, coins, exp_short);
        @(negedge CLK);
        Credit = credit;
        Start  = 1'b1;
        @(posedge CLK);
        #1;
        Start  = 1'b0;
        Credit = 8'($urandom_range(0, 255));
        j = 0;
        while (exp_q.size() > 0) begin
            @(negedge CLK);
            j++;
            e = exp_q.pop_front();
            check($sformatf("c%0d trace@k+%0d", credit, j), 32'(observed()), 32'(e));
            if (j == 6 * n + 2)
                check($sformatf("c%0d remaining", credit), 32'(Remaining), 32'(exp_rem));
            if (poke != 0 && j == poke) begin
                Start = 1'b1; Refill = 1'b1; Credit = 8'd255;
            end else if (poke != 0 && j == poke + 1) begin
                Start = 1'b0; Refill = 1'b0;
            end
        end
    endtask

    // Refill with a simultaneous Start. Refill wins, so the unit must stay idle.
    task automatic do_refill(input string tag);
        @(negedge CLK);
        Refill = 1'b1;
        Start  = 1'b1;
        Credit = 8'd50;
        @(posedge CLK);
        #1;
        Refill = 1'b0;
        Start  = 1'b0;
        @(negedge CLK);
        check({tag, " busy"}, 32'(Busy), 32'd0);
        check({tag, " empty"}, 32'(Empty), 32'd0);
    endtask

    initial begin
        RST = 1'b0; Start = 1'b0; Refill = 1'b0; Credit = 8'd0;

        // Reset held for 3 edges while the inputs toggle.
        repeat (3) begin
            @(negedge CLK);
            Start  = 1'($urandom_range(0, 1));
            Refill = 1'($urandom_range(0, 1));
            Credit = 8'($urandom_range(0, 255));
        end
        check("reset outputs", 32'(observed()), 32'd0);
        check("reset remaining", 32'(Remaining), 32'd0);
        check("reset empty", 32'(Empty), 32'd0);
        Start = 1'b0; Refill = 1'b0;
        RST = 1'b1;

        // Greedy runs on a full inventory.
        run_credit(8'd165, 4, {C_V, C_T, C_F, C_D}, 1'b0, 8'd0, 0);
        run_credit(8'd0,   0, 16'h0, 1'b0, 8'd0, 0);
        run_credit(8'd3,   0, 16'h0, 1'b1, 8'd3, 0);
        run_credit(8'd7,   1, {12'h0, C_V}, 1'b1, 8'd2, 0);
        run_credit(8'd30,  3, {4'h0, C_T, C_T, C_T}, 1'b0, 8'd0, 0);
        run_credit(8'd255, 4, {C_V, C_F, C_D, C_D}, 1'b0, 8'd0, 0);

        // Dollar depletion; the ninth request falls back to two fifties.
        do_refill("refill1");
        for (int r = 0; r < 8; r++) run_credit(8'd100, 1, {12'h0, C_D}, 1'b0, 8'd0, 0);
        check("empty after 8 dollars", 32'(Empty), 32'(4'b1000));
        run_credit(8'd100, 2, {8'h0, C_F, C_F}, 1'b0, 8'd0, 0);
        check("empty after fifties", 32'(Empty), 32'(4'b1000));
        do_refill("refill2");

        // Start and Refill raised while busy are ignored.
        run_credit(8'd10, 1, {12'h0, C_T}, 1'b0, 8'd0, 3);

        // Reset asserted during the 2nd pulse cycle aborts the request.
        @(negedge CLK);
        Credit = 8'd100;
        Start  = 1'b1;
        @(posedge CLK);
        #1;
        Start = 1'b0;
        repeat (3) @(negedge CLK);
        check("abort 2nd pulse", 32'(DispDollar), 32'd1);
        RST = 1'b0;
        @(negedge CLK);
        check("abort outputs", 32'(observed()), 32'd0);
        check("abort remaining", 32'(Remaining), 32'd0);
        check("abort empty", 32'(Empty), 32'd0);
        RST = 1'b1;

        // Reset restored the dollar count to 8, so eight more dollars are available.
        for (int r = 0; r < 8; r++) run_credit(8'd100, 1, {12'h0, C_D}, 1'b0, 8'd0, 0);
        check("empty after reset restock", 32'(Empty), 32'(4'b1000));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vend_change_dispenser.md
# vend_change_dispenser

Change-return sequencer for the vending machine datapath. After a sale it takes the leftover credit in cents and drives the coin-return solenoids one coin at a time, largest denomination first. It tracks a finite inventory of each coin and reports when exact change cannot be made. It sits beside `vending_machine` and consumes its `Money` value once `Deliver` has fired.

## Interface
- `PULSE_CYCLES`, 3: cycles each solenoid output is held high (30 ns at a 10 ns clock).
- `GAP_CYCLES`, 2: low cycles after each pulse, before the next selection.
- `INIT_COUNT`, 8: coins of each denomination loaded at reset and on `Refill`.

Ports:
- `CLK`, in, 1: single clock, rising edge.
- `RST`, in, 1: synchronous, active-low reset.
- `Start`, in, 1: request to dispense `Credit`; sampled only in IDLE.
- `Credit`, in, 8: change owed in cents, 0–255.
- `Refill`, in, 1: reload all four inventories to `INIT_COUNT`; sampled only in IDLE.
- `DispDollar`, `DispFifty`, `DispTen`, `DispFive`, out, 1 each: solenoid pulses for 100c, 50c, 10c and 5c. They are mutually exclusive.
- `Remaining`, out, 8: cents still owed, registered.
- `Empty`, out, 4: `{dollar,fifty,ten,five}` inventory count equals zero.
- `Busy`, out, 1: high in SELECT, PULSE and GAP.
- `Done`, out, 1: single-cycle completion strobe.
- `Short`, out, 1: last request ended with `Remaining` != 0. Held until the next accepted `Start` or reset.

## Operation
- States: IDLE, SELECT, PULSE, GAP, DONE. One-hot or binary encoding is implementer's choice.
- Inventories are four 8-bit counters.
- Reset (`RST`=0 at an edge):
  - state goes to IDLE;
  - all `Disp*`, `Busy`, `Done`, `Short` = 0;
  - `Remaining` = 0;
  - all counts = `INIT_COUNT`;
  - `Empty` = 0 when `INIT_COUNT` > 0.
- Reset mid-operation aborts immediately. No partial pulse continues after the reset edge.
- IDLE:
  - `Refill`=1 reloads the counts and stays in IDLE.
  - `Refill` has priority: `Start` in the same cycle is ignored.
  - Otherwise `Start`=1 latches `Credit` into `Remaining`, clears `Short`, and goes to SELECT.
- SELECT uses greedy choice. Pick the largest d in {100, 50, 10, 5} with d <= `Remaining` and count(d) > 0.
  - If `Remaining` = 0, go to DONE with `Short`=0.
  - If no d qualifies, go to DONE with `Short`=1.
  - Otherwise go to PULSE. On that transition, subtract d from `Remaining` and decrement count(d).
- Greedy is final. No backtracking is done, even if a non-greedy combination exists.
- PULSE: the selected `Disp*` is high for exactly `PULSE_CYCLES` cycles, then the FSM goes to GAP.
- GAP: all `Disp*` are low for `GAP_CYCLES` cycles, then the FSM goes to SELECT.
- DONE: `Done`=1 for one cycle, then the FSM goes to IDLE.
- `Start` and `Refill` outside IDLE are ignored, with no queuing.
- Arithmetic:
  - `Remaining` never underflows, because of the d <= `Remaining` guard.
  - Counts never underflow, because of the count > 0 guard.
  - A non-multiple-of-5 residue (1–4c) always ends with `Short`=1.

## Timing
- All outputs are registered.
- Taking `Start` sampled at edge k:
  - `Busy`=1 from cycle k+1 (SELECT).
  - The first `Disp*` is high during cycles k+2 .. k+1+`PULSE_CYCLES`.
- Coin period is `PULSE_CYCLES` + `GAP_CYCLES` + 1 (SELECT) = 6 cycles at the defaults.
- Timing for N coins:
  - DONE occurs at cycle k+2+6N.
  - `Busy` falls in that same cycle.
  - IDLE resumes at k+3+6N.
  - For N=0, `Done` is at k+2.
- `Remaining` and count updates become visible in the first PULSE cycle of each coin.
- A new `Start` can be accepted in the IDLE cycle that immediately follows DONE.

## Test plan
- **Reset:** hold `RST`=0 for 3 cycles, with stimulus toggling. Required: all `Disp*`/`Busy`/`Done`/`Short` = 0, `Remaining`=0, `Empty`=4'b0000.
- **Full greedy run:** `Credit`=165, `Start` at edge k. Required:
  - `DispDollar`, `DispFifty`, `DispTen`, `DispFive` each pulse for 3 cycles, in that order, starting at k+2, k+8, k+14, k+20.
  - `Done` at k+26, `Short`=0, `Remaining`=0.
- **Zero credit:** `Credit`=0. Required: no pulses, `Done` at k+2, `Short`=0.
- **Depletion:** run `Credit`=100 nine times. Required:
  - Runs 1–8 produce one `DispDollar` each, and `Empty[3]`=1 after run 8.
  - Run 9 produces two `DispFifty` pulses, with `Done` at k+14.
  - A following `Refill` clears `Empty[3]`.
- **Short change:** `Credit`=3. Required: no pulses, `Done` at k+2, `Short`=1, `Remaining`=3.
- **Abort and ignore:** a `Start` during `Busy` is ignored. Pulling `RST` low in the 2nd PULSE cycle gives all outputs 0 on the next cycle and counts = `INIT_COUNT`.
